// File: rtl/missile_ctl_if.sv
// Missile scheduler signal bundle: fire/ship position/hit inputs and per-slot
// missile coordinates. The scheduler attaches to the slave side.
interface missile_ctl_if #(
  parameter int SLOTS = 4
);
  logic                   fire;
  logic [10:0]            xpos_ship;
  logic [SLOTS-1:0]       hit;
  logic [SLOTS-1:0]       missile_valid;
  logic [11*SLOTS-1:0]    missile_x;
  logic [11*SLOTS-1:0]    missile_y;
  logic                   shot;
  logic                   full;

  modport master (
    output fire, xpos_ship, hit,
    input  missile_valid, missile_x, missile_y, shot, full
  );

  modport slave (
    input  fire, xpos_ship, hit,
    output missile_valid, missile_x, missile_y, shot, full
  );
endinterface

// File: rtl/missile_ctl.sv
// Player missile scheduler: allocates slots on fire presses, moves airborne
// missiles upward on a periodic tick and retires them at the top or on a hit.
//
// Per-slot state | meaning
// ---------------+-------------------------------------------------
// FREE           | slot idle, available for the next launch
// FLYING         | missile airborne, moves up SPEED pixels per tick
module missile_ctl #(
  parameter int SLOTS          = 4,
  parameter int STEP_PERIOD    = 15000,
  parameter int SPEED          = 4,
  parameter int COOLDOWN_STEPS = 20,
  parameter int SHIP_WIDTH     = 48,
  parameter int SHIP_Y         = 700,
  parameter int MISSILE_WIDTH  = 4,
  parameter int MISSILE_HEIGHT = 16,
  parameter int Y_MIN          = 0
) (
  input logic          pclk,
  input logic          rst,
  missile_ctl_if.slave bus
);

  localparam int STEP_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int CD_W   = (COOLDOWN_STEPS > 0) ? $clog2(COOLDOWN_STEPS + 1) : 1;

  localparam logic [10:0] LAUNCH_X_OFS = 11'(SHIP_WIDTH / 2 - MISSILE_WIDTH / 2);
  localparam logic [10:0] LAUNCH_Y     = 11'(SHIP_Y - MISSILE_HEIGHT);
  localparam logic [10:0] SPEED_V      = 11'(SPEED);
  localparam logic [10:0] RETIRE_Y     = 11'(Y_MIN + SPEED);
  localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN_STEPS);

  typedef enum logic {
    FREE   = 1'b0,
    FLYING = 1'b1
  } slot_state_t;

  slot_state_t       state_q [SLOTS];
  slot_state_t       state_d [SLOTS];
  logic [10:0]       x_q [SLOTS];
  logic [10:0]       x_d [SLOTS];
  logic [10:0]       y_q [SLOTS];
  logic [10:0]       y_d [SLOTS];

  logic [STEP_W-1:0] step_cnt;
  logic              tick;
  logic              fire_d;
  logic              fire_arm;
  logic              fire_edge;
  logic [CD_W-1:0]   cooldown;
  logic              full_q;
  logic              shot_q;
  logic              launch;
  logic              alloc_found;
  logic [SLOTS-1:0]  alloc_oh;
  logic [SLOTS-1:0]  valid_q;
  logic [SLOTS-1:0]  valid_d;
  logic [11*SLOTS-1:0] x_flat;
  logic [11*SLOTS-1:0] y_flat;

  assign tick = (step_cnt == STEP_W'(STEP_PERIOD - 1));

  // fire_arm blocks a key held through reset release until it has been seen low
  assign fire_edge = bus.fire & ~fire_d & fire_arm;
  assign launch    = fire_edge & (cooldown == '0) & ~full_q & alloc_found;

  always_ff @(posedge pclk) begin
    if (rst) begin
      step_cnt <= '0;
      fire_d   <= 1'b0;
      fire_arm <= ~bus.fire;
      cooldown <= '0;
      full_q   <= 1'b0;
      shot_q   <= 1'b0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + STEP_W'(1);
      fire_d   <= bus.fire;
      if (!bus.fire) fire_arm <= 1'b1;
      if (launch) cooldown <= CD_LOAD;
      else if (tick && cooldown != '0) cooldown <= cooldown - CD_W'(1);
      full_q   <= &valid_d;
      shot_q   <= launch;
    end
  end

  // lowest-index slot that is free in the current cycle
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (state_q[i] == FREE && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (rst) begin
        state_q[i] <= FREE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end else begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
      end
    end
  end

  // hit wins over a tick move; a slot launched this cycle is still FREE here so it never moves
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      case (state_q[i])
        FREE: begin
          if (launch && alloc_oh[i]) begin
            state_d[i] = FLYING;
            x_d[i]     = bus.xpos_ship + LAUNCH_X_OFS;
            y_d[i]     = LAUNCH_Y;
          end
        end
        FLYING: begin
          if (bus.hit[i]) begin
            state_d[i] = FREE;
          end else if (tick) begin
            if (y_q[i] < RETIRE_Y) state_d[i] = FREE;
            else                   y_d[i]     = y_q[i] - SPEED_V;
          end
        end
        default: state_d[i] = FREE;
      endcase
    end
  end

  always_comb begin
    valid_q = '0;
    valid_d = '0;
    x_flat  = '0;
    y_flat  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      valid_q[i]         = (state_q[i] == FLYING);
      valid_d[i]         = (state_d[i] == FLYING);
      x_flat[11*i +: 11] = x_q[i];
      y_flat[11*i +: 11] = y_q[i];
    end
  end

  assign bus.missile_valid = valid_q;
  assign bus.missile_x     = x_flat;
  assign bus.missile_y     = y_flat;
  assign bus.shot          = shot_q;
  assign bus.full          = full_q;

endmodule

// File: tb/tb_missile_ctl.sv
// Directed bench for missile_ctl with STEP_PERIOD=4, SPEED=8, COOLDOWN_STEPS=2.
module tb_missile_ctl;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ecount = 0;

  missile_ctl_if #(.SLOTS(4)) mif ();

  missile_ctl #(
    .SLOTS(4), .STEP_PERIOD(4), .SPEED(8), .COOLDOWN_STEPS(2)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (mif)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // edge k after reset release is a tick edge when k % 4 == 0
  task automatic step();
    @(posedge pclk);
    #1;
    ecount++;
  endtask

  task automatic press();
    mif.fire = 1'b1;
    step();
    mif.fire = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mif.fire = 1'b0;
    mif.hit  = '0;
    step();
    step();
    rst = 1'b0;
    ecount = 0;
  endtask

  task automatic step_until(input int e);
    while (ecount < e) step();
  endtask

  function automatic logic [10:0] slot_x(input int i);
    return 11'(mif.missile_x >> (11 * i));
  endfunction

  function automatic logic [10:0] slot_y(input int i);
    return 11'(mif.missile_y >> (11 * i));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int ticks;
    int shots;
    bit done;

    mif.fire = 1'b0;
    mif.hit = '0;
    mif.xpos_ship = 11'd512;

    // reset values and single launch with a long hold
    do_reset();
    check_val("rst_valid", mif.missile_valid, 0);
    check_val("rst_x", mif.missile_x, 0);
    check_val("rst_y", mif.missile_y, 0);
    check_val("rst_shot", mif.shot, 0);
    check_val("rst_full", mif.full, 0);

    mif.fire = 1'b1;
    step();
    check_val("launch_valid", mif.missile_valid, 4'b0001);
    check_val("launch_x", slot_x(0), 534);
    check_val("launch_y", slot_y(0), 684);
    check_val("launch_shot", mif.shot, 1);

    ticks = 0; shots = 0; done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (c == 50) mif.fire = 1'b0;
      step();
      shots += int'(mif.shot);
      if (c == 0) check_val("shot_one_cycle", mif.shot, 0);
      if (ecount % 4 == 0) begin
        ticks++;
        if (ticks == 1) check_val("first_move", slot_y(0), 676);
        if (ticks == 85) begin
          check_val("last_y", slot_y(0), 4);
          check_val("last_valid", mif.missile_valid, 4'b0001);
        end
        if (ticks == 86) begin
          check_val("retired", mif.missile_valid, 0);
          done = 1;
        end
      end
    end
    check_val("hold_no_relaunch", shots, 0);
    check_val("retire_reached", done, 1);

    // cooldown
    do_reset();
    mif.xpos_ship = 11'd512;
    press();                                   // E1
    step();                                    // E2
    press();                                   // E3, cooldown 2
    check_val("cd_drop1_shot", mif.shot, 0);
    check_val("cd_drop1_valid", mif.missile_valid, 4'b0001);
    step();                                    // E4 tick
    press();                                   // E5, cooldown 1
    check_val("cd_drop2_shot", mif.shot, 0);
    check_val("cd_drop2_valid", mif.missile_valid, 4'b0001);
    step_until(8);
    press();                                   // E9, cooldown 0
    check_val("cd_ok_valid", mif.missile_valid, 4'b0011);
    check_val("cd_ok_shot", mif.shot, 1);
    check_val("cd_ok_x1", slot_x(1), 534);
    check_val("cd_ok_y1", slot_y(1), 684);
    check_val("cd_ok_y0", slot_y(0), 668);

    // full pool
    do_reset();
    mif.xpos_ship = 11'd100; press();          // E1
    step_until(8);
    mif.xpos_ship = 11'd200; press();          // E9
    step_until(16);
    mif.xpos_ship = 11'd300; press();          // E17
    check_val("three_full", mif.full, 0);
    check_val("three_x2", slot_x(2), 322);
    step_until(24);
    mif.xpos_ship = 11'd400; press();          // E25
    check_val("four_full", mif.full, 1);
    check_val("four_valid", mif.missile_valid, 4'b1111);
    check_val("four_x3", slot_x(3), 422);
    step_until(32);
    press();                                   // E33
    check_val("fifth_shot", mif.shot, 0);
    check_val("fifth_valid", mif.missile_valid, 4'b1111);
    mif.hit = 4'b0100;
    step();                                    // E34
    mif.hit = '0;
    check_val("hit2_valid", mif.missile_valid, 4'b1011);
    check_val("hit2_full", mif.full, 0);
    mif.xpos_ship = 11'd600; press();          // E35
    check_val("realloc_valid", mif.missile_valid, 4'b1111);
    check_val("realloc_shot", mif.shot, 1);
    check_val("realloc_x2", slot_x(2), 622);
    check_val("realloc_y2", slot_y(2), 684);
    check_val("realloc_x0", slot_x(0), 122);
    check_val("realloc_y0", slot_y(0), 620);
    check_val("realloc_y3", slot_y(3), 668);

    // simultaneous events
    do_reset();
    mif.xpos_ship = 11'd512;
    press();                                   // E1
    step_until(8);
    press();                                   // E9
    step_until(11);
    mif.hit = 4'b0010;
    step();                                    // E12 tick + hit[1]
    mif.hit = '0;
    check_val("hit_tick_valid", mif.missile_valid, 4'b0001);
    check_val("hit_tick_y0", slot_y(0), 660);
    step_until(19);
    press();                                   // E20 tick + launch
    check_val("launch_tick_valid", mif.missile_valid, 4'b0011);
    check_val("launch_tick_y1", slot_y(1), 684);
    check_val("launch_tick_y0", slot_y(0), 644);
    check_val("launch_tick_shot", mif.shot, 1);
    step();                                    // E21
    check_val("launch_tick_hold_y1", slot_y(1), 684);

    // reset mid-flight with fire held
    step_until(28);
    press();                                   // E29
    check_val("three_flying", mif.missile_valid, 4'b0111);
    mif.fire = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ecount = 0;
    check_val("mid_rst_valid", mif.missile_valid, 0);
    check_val("mid_rst_x", mif.missile_x, 0);
    check_val("mid_rst_y", mif.missile_y, 0);
    check_val("mid_rst_shot", mif.shot, 0);
    check_val("mid_rst_full", mif.full, 0);
    shots = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      shots += int'(mif.shot);
    end
    check_val("held_no_launch_shots", shots, 0);
    check_val("held_no_launch_valid", mif.missile_valid, 0);
    mif.fire = 1'b0;
    step();
    press();
    check_val("repress_valid", mif.missile_valid, 4'b0001);
    check_val("repress_shot", mif.shot, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
